// File: rtl/sha_auth_ctrl.sv
// Streams a pre-padded message into a SHA-256 core one 16-word block at a time,
// kicks init/next per block, then compares the final digest with the expected one.
module sha_auth_ctrl #(
    parameter int unsigned BLOCK_WORDS    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             word_valid_i,
    input  logic [31:0]      word_data_i,
    input  logic             word_last_i,
    output logic             word_ready_o,
    input  logic [255:0]     exp_digest_i,
    output logic             sha_reset_n_o,
    output logic             sha_cs_o,
    output logic             sha_we_o,
    output logic [3:0]       sha_address_o,
    output logic [31:0]      sha_write_data_o,
    output logic             sha_init_o,
    output logic             sha_next_o,
    input  logic             sha_ready_i,
    input  logic             sha_digest_valid_i,
    input  logic [255:0]     sha_digest_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             err_o,
    output logic [CNT_W-1:0] block_cnt_o
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SRST, ST_LOAD, ST_KICK, ST_WAIT, ST_CMP, ST_DONE, ST_ERR
    } state_t;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic               r_srst, w_srst;
    logic [TMO_W-1:0]   r_wcnt, w_wcnt;
    logic               r_kicked, w_kicked;
    logic               r_final, w_final;
    logic               r_word_ready, w_word_ready;
    logic               r_sha_reset_n, w_sha_reset_n;
    logic               r_wr, w_wr;
    logic [IDX_W-1:0]   r_addr, w_addr;
    logic [WORD_W-1:0]  r_wdata, w_wdata;
    logic               r_init, w_init;
    logic               r_next, w_next;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_pass, w_pass;
    logic               r_err, w_err;
    logic [CNT_W-1:0]   r_blk_cnt, w_blk_cnt;

    // Next-state and next-output logic; outputs line up with the state they belong to
    always_comb begin
        w_state       = r_state;
        w_idx         = r_idx;
        w_srst        = r_srst;
        w_wcnt        = r_wcnt;
        w_kicked      = r_kicked;
        w_final       = r_final;
        w_word_ready  = 1'b0;
        w_sha_reset_n = r_sha_reset_n;
        w_wr          = 1'b0;
        w_addr        = r_addr;
        w_wdata       = r_wdata;
        w_init        = 1'b0;
        w_next        = 1'b0;
        w_done        = r_done;
        w_pass        = r_pass;
        w_err         = r_err;
        w_blk_cnt     = r_blk_cnt;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    w_state       = ST_SRST;
                    w_srst        = 1'b0;
                    w_sha_reset_n = 1'b0;
                    w_done        = 1'b0;
                    w_pass        = 1'b0;
                    w_err         = 1'b0;
                    w_blk_cnt     = '0;
                    w_kicked      = 1'b0;
                    w_final       = 1'b0;
                    w_idx         = '0;
                end
            end
            ST_SRST: begin
                if (r_srst) begin
                    w_state       = ST_LOAD;
                    w_sha_reset_n = 1'b1;
                    w_word_ready  = 1'b1;
                end else begin
                    w_srst = 1'b1;
                end
            end
            ST_LOAD: begin
                // ready low inside LOAD marks the write cycle of the block's last word
                if (!r_word_ready) begin
                    w_state  = ST_KICK;
                    w_init   = ~r_kicked;
                    w_next   = r_kicked;
                    w_kicked = 1'b1;
                    if (r_blk_cnt != '1) w_blk_cnt = r_blk_cnt + CNT_W'(1);
                end else begin
                    w_word_ready = 1'b1;
                    if (word_valid_i) begin
                        w_wr    = 1'b1;
                        w_addr  = r_idx;
                        w_wdata = word_data_i;
                        w_idx   = r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX) begin
                            w_word_ready = 1'b0;
                            w_final      = word_last_i;
                        end else if (word_last_i) begin
                            w_word_ready = 1'b0;
                            w_state      = ST_ERR;
                            w_err        = 1'b1;
                        end
                    end
                end
            end
            ST_KICK: begin
                w_state = ST_WAIT;
                w_wcnt  = '0;
            end
            ST_WAIT: begin
                // the first WAIT cycle ignores ready while the core reacts to the kick
                if ((r_wcnt != '0) && sha_ready_i) begin
                    if (r_final) begin
                        w_state = ST_CMP;
                    end else begin
                        w_state      = ST_LOAD;
                        w_word_ready = 1'b1;
                    end
                end else if (r_wcnt == TMO_LAST) begin
                    w_state = ST_ERR;
                    w_err   = 1'b1;
                end else begin
                    w_wcnt = r_wcnt + TMO_W'(1);
                end
            end
            ST_CMP: begin
                if (sha_digest_valid_i) begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                    w_pass  = (sha_digest_i == exp_digest_i);
                end else begin
                    w_state = ST_ERR;
                    w_err   = 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        w_busy = (w_state != ST_IDLE) && (w_state != ST_DONE) && (w_state != ST_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_srst        <= 1'b0;
            r_wcnt        <= '0;
            r_kicked      <= 1'b0;
            r_final       <= 1'b0;
            r_word_ready  <= 1'b0;
            r_sha_reset_n <= 1'b0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_init        <= 1'b0;
            r_next        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= 1'b0;
            r_blk_cnt     <= '0;
        end else begin
            r_state       <= w_state;
            r_idx         <= w_idx;
            r_srst        <= w_srst;
            r_wcnt        <= w_wcnt;
            r_kicked      <= w_kicked;
            r_final       <= w_final;
            r_word_ready  <= w_word_ready;
            r_sha_reset_n <= w_sha_reset_n;
            r_wr          <= w_wr;
            r_addr        <= w_addr;
            r_wdata       <= w_wdata;
            r_init        <= w_init;
            r_next        <= w_next;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_pass        <= w_pass;
            r_err         <= w_err;
            r_blk_cnt     <= w_blk_cnt;
        end
    end

    assign word_ready_o     = r_word_ready;
    assign sha_reset_n_o    = r_sha_reset_n;
    assign sha_cs_o         = r_wr;
    assign sha_we_o         = r_wr;
    assign sha_address_o    = r_addr;
    assign sha_write_data_o = r_wdata;
    assign sha_init_o       = r_init;
    assign sha_next_o       = r_next;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign err_o            = r_err;
    assign block_cnt_o      = r_blk_cnt;

endmodule

// File: tb/tb_sha_auth_ctrl.sv
// Bench for sha_auth_ctrl: a real SHA-256 core model plus a message-level reference
// that predicts the writes, kicks, block count, timing and pass/err outcome.
module tb_sha_auth_ctrl;

    localparam int TMO = 1024;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         word_valid_i = 1'b0;
    logic [31:0]  word_data_i = '0;
    logic         word_last_i = 1'b0;
    logic         word_ready_o;
    logic [255:0] exp_digest_i = '0;
    logic         sha_reset_n_o, sha_cs_o, sha_we_o, sha_init_o, sha_next_o;
    logic [3:0]   sha_address_o;
    logic [31:0]  sha_write_data_o;
    logic         sha_ready_i = 1'b1;
    logic         sha_digest_valid_i = 1'b0;
    logic [255:0] sha_digest_i = '0;
    logic         busy_o, done_o, pass_o, err_o;
    logic [15:0]  block_cnt_o;

    sha_auth_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_last_i(word_last_i),
        .word_ready_o(word_ready_o), .exp_digest_i(exp_digest_i),
        .sha_reset_n_o(sha_reset_n_o), .sha_cs_o(sha_cs_o), .sha_we_o(sha_we_o),
        .sha_address_o(sha_address_o), .sha_write_data_o(sha_write_data_o),
        .sha_init_o(sha_init_o), .sha_next_o(sha_next_o), .sha_ready_i(sha_ready_i),
        .sha_digest_valid_i(sha_digest_valid_i), .sha_digest_i(sha_digest_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_o(err_o),
        .block_cnt_o(block_cnt_o));

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, s_cyc = 0;
    int n_init = 0, n_next = 0, n_srst = 0;
    int t_done = -1, t_err = -1, t_rdy = -1;
    logic prev_done = 1'b0, prev_err = 1'b0;
    logic [31:0] msg [48];
    logic [35:0] exp_q [$];
    int core_lat = 3;
    bit core_hang = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] s, r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        s = {a, b, c, d, e, f, g, h};
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + s[255-32*i -: 32];
        return r;
    endfunction

    // Reference digest of the first nw words of msg
    function automatic logic [255:0] digest_of(input int nw);
        logic [255:0] hv;
        logic [511:0] blk;
        hv = IV;
        for (int b = 0; b < nw / 16; b++) begin
            for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = msg[16*b+i];
            hv = sha_compress(hv, blk);
        end
        return hv;
    endfunction

    // SHA core model: captures written words, hashes on init/next, answers after core_lat cycles
    logic [31:0]  core_mem [16];
    logic [255:0] core_h = '0;
    int           core_rem = 0;
    bit           core_busy = 1'b0;
    always @(posedge clk_i) begin
        logic [511:0] blk;
        logic [255:0] hn;
        cyc <= cyc + 1;
        if (!sha_reset_n_o) begin
            sha_ready_i        <= 1'b1;
            sha_digest_valid_i <= 1'b0;
            core_busy          <= 1'b0;
        end else begin
            if (sha_cs_o && sha_we_o) core_mem[sha_address_o] <= sha_write_data_o;
            if (sha_init_o || sha_next_o) begin
                for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = core_mem[i];
                hn = sha_compress(sha_init_o ? IV : core_h, blk);
                core_h             <= hn;
                sha_ready_i        <= 1'b0;
                sha_digest_valid_i <= 1'b0;
                core_busy          <= 1'b1;
                core_rem           <= core_lat - 1;
            end else if (core_busy && !core_hang) begin
                if (core_rem == 0) begin
                    sha_ready_i        <= 1'b1;
                    sha_digest_valid_i <= 1'b1;
                    sha_digest_i       <= core_h;
                    core_busy          <= 1'b0;
                end else begin
                    core_rem <= core_rem - 1;
                end
            end
        end
    end

    // Per-cycle compare process: write stream against the expected queue plus output invariants
    always @(negedge clk_i) begin
        logic [35:0] e;
        if (rst_ni) begin
            chk("cs_eq_we", sha_cs_o, sha_we_o);
            chk("pass_and_err", pass_o & err_o, 1'b0);
            chk("pass_without_done", pass_o & ~done_o, 1'b0);
            chk("init_and_next", sha_init_o & sha_next_o, 1'b0);
            chk("ready_while_idle", word_ready_o & ~busy_o, 1'b0);
            if (sha_init_o) n_init++;
            if (sha_next_o) n_next++;
            if (busy_o && !sha_reset_n_o) n_srst++;
            if (word_ready_o && t_rdy < 0) t_rdy = cyc;
            if (done_o && !prev_done) t_done = cyc;
            if (err_o && !prev_err) t_err = cyc;
            if (sha_we_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", sha_address_o, e[35:32]);
                    chk("wr_data", sha_write_data_o, e[31:0]);
                end
            end
        end
        prev_done = done_o;
        prev_err  = err_o;
    end

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic load_two();
        for (int i = 0; i < 32; i++) msg[i] = '0;
        for (int i = 0; i < 14; i++) msg[i] = 32'h61626364 + 32'(i) * 32'h01010101;
        msg[14] = 32'h80000000;
        msg[31] = 32'h000001c0;
    endtask

    task automatic do_start();
        n_init = 0; n_next = 0; n_srst = 0;
        t_done = -1; t_err = -1; t_rdy = -1;
        start_i = 1'b1;
        s_cyc = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send_word(input int idx, input int gap, input bit last);
        bit acc;
        int n;
        while (int'($urandom_range(99)) < gap) begin @(posedge clk_i); #1; end
        word_valid_i = 1'b1; word_data_i = msg[idx]; word_last_i = last;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = word_ready_o;
            if (acc) exp_q.push_back({4'(idx % 16), msg[idx]});
            @(posedge clk_i); #1;
            n++;
        end
        word_valid_i = 1'b0; word_last_i = 1'b0;
        if (!acc) chk("word_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_msg(input int nw, input int gap, input int last_at);
        for (int i = 0; i < nw; i++) send_word(i, gap, i == last_at);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done_o || err_o) && n < budget) begin @(negedge clk_i); n++; end
        if (!(done_o || err_o)) chk("end_timeout", 1'b0, 1'b1);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, word_ready_o, 1'b0);
        chk({tag, "_sha_rst_n"}, sha_reset_n_o, 1'b0);
        chk({tag, "_cs_we"}, {sha_cs_o, sha_we_o}, 2'b00);
        chk({tag, "_addr_data"}, {sha_address_o, sha_write_data_o}, 36'h0);
        chk({tag, "_init_next"}, {sha_init_o, sha_next_o}, 2'b00);
        chk({tag, "_busy_done_pass_err"}, {busy_o, done_o, pass_o, err_o}, 4'h0);
        chk({tag, "_blk_cnt"}, block_cnt_o, 16'h0);
    endtask

    // Full message run checked against the reference outcome
    task automatic run_full(input string tag, input int nw, input int gap, input logic [255:0] exp);
        logic exp_pass;
        exp_pass = (digest_of(nw) == exp);
        exp_digest_i = exp;
        do_start();
        send_msg(nw, gap, nw - 1);
        wait_end(200);
        chk({tag, "_done"}, done_o, 1'b1);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_pass"}, pass_o, exp_pass);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_blk_cnt"}, block_cnt_o, 16'(nw / 16));
        chk({tag, "_n_init"}, n_init, 1);
        chk({tag, "_n_next"}, n_next, nw / 16 - 1);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        chk({tag, "_srst_cycles"}, n_srst, 2);
        chk({tag, "_first_ready"}, t_rdy, s_cyc + 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] ex;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_vals("por");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Reference model pinned to published vectors
        load_abc();
        chk("model_abc", digest_of(16), ABC_DIG);
        load_two();
        chk("model_two", digest_of(32), TWO_DIG);

        // "abc", back-to-back words: exact done latency
        load_abc();
        core_lat = 3;
        run_full("abc", 16, 0, ABC_DIG);
        chk("abc_pass_lit", pass_o, 1'b1);
        chk("abc_latency", t_done, s_cyc + 23 + core_lat);

        // Two blocks with random valid gaps
        load_two();
        core_lat = 5;
        run_full("two", 32, 40, TWO_DIG);
        chk("two_pass_lit", pass_o, 1'b1);

        // Corrupted expected digest
        load_abc();
        ex = ABC_DIG ^ 256'h1;
        run_full("abc_bad", 16, 20, ex);
        chk("abc_bad_pass_lit", pass_o, 1'b0);

        // word_last_i on index 7
        load_abc();
        exp_digest_i = ABC_DIG;
        do_start();
        send_msg(8, 0, 7);
        wait_end(50);
        chk("early_last_err", err_o, 1'b1);
        chk("early_last_err_time", t_err, s_cyc + 11);
        chk("early_last_done_pass", {done_o, pass_o}, 2'b00);
        chk("early_last_kicks", n_init + n_next, 0);
        chk("early_last_blk_cnt", block_cnt_o, 16'h0);
        chk("early_last_writes_left", exp_q.size(), 0);

        // Core never becomes ready: timeout
        load_abc();
        core_hang = 1'b1;
        do_start();
        send_msg(16, 0, 15);
        wait_end(TMO + 100);
        chk("tmo_err", err_o, 1'b1);
        chk("tmo_err_time", t_err, s_cyc + 21 + TMO);
        chk("tmo_done_pass", {done_o, pass_o}, 2'b00);
        chk("tmo_blk_cnt", block_cnt_o, 16'h1);
        core_hang = 1'b0;
        do_start();
        chk("restart_err_clear", err_o, 1'b0);
        chk("restart_busy", busy_o, 1'b1);
        chk("restart_sha_rst_n", sha_reset_n_o, 1'b0);
        chk("restart_blk_cnt", block_cnt_o, 16'h0);
        send_msg(16, 0, 15);
        wait_end(200);
        chk("restart_done_pass", {done_o, pass_o, err_o}, 3'b110);

        // Asynchronous reset while loading index 9
        load_abc();
        do_start();
        send_msg(9, 0, -1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk_i);
        #1;
        chk("post_reset_idle", {busy_o, word_ready_o}, 2'b00);
        run_full("after_rst", 16, 0, ABC_DIG);
        chk("after_rst_pass_lit", pass_o, 1'b1);

        // Random messages, gaps, core latencies and expected digests
        for (int r = 0; r < 5; r++) begin
            int nb;
            nb = int'($urandom_range(3, 1));
            for (int i = 0; i < 16 * nb; i++) msg[i] = $urandom();
            core_lat = int'($urandom_range(6, 1));
            if ($urandom_range(1) == 1) ex = digest_of(16 * nb);
            else for (int j = 0; j < 8; j++) ex[255-32*j -: 32] = $urandom();
            run_full("rand", 16 * nb, int'($urandom_range(50)), ex);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha_auth_ctrl.md
Name: sha_auth_ctrl

Overview:
- Sequencer between the PMU bitstream path and the SHA-256 core.
- Accepts a pre-padded message as a stream of 32-bit words and writes each 16-word block into the core.
- Issues init for the first block and next for each later block, and waits for the core after each block.
- After the last block, compares the final digest against an expected digest and reports done/pass/err to the PMU core, which uses the result to gate the FPGA lock/unlock decision.

Parameters:
- BLOCK_WORDS, 16, words per SHA block; fixed, index width 4.
- TIMEOUT_CYCLES, 1024, maximum clk_i cycles to wait for sha_ready_i after a kick.
- CNT_W, 16, width of the block counter.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse; begins a new message. Honoured only in IDLE, DONE or ERR.
- word_valid_i  input  1  message word valid.
- word_data_i  input  32  message word, big-endian SHA word order.
- word_last_i  input  1  qualifies the final word of the message.
- word_ready_o  output  1  controller accepts a word this cycle.
- exp_digest_i  input  256  expected digest; held stable from start_i until done_o.
- sha_reset_n_o  output  1  active-low reset to the SHA core.
- sha_cs_o  output  1  SHA chip select, asserted with sha_we_o.
- sha_we_o  output  1  SHA block-word write strobe.
- sha_address_o  output  4  block-word index 0..15.
- sha_write_data_o  output  32  block word.
- sha_init_o  output  1  one-cycle pulse; first block.
- sha_next_o  output  1  one-cycle pulse; subsequent blocks.
- sha_ready_i  input  1  SHA core idle.
- sha_digest_valid_i  input  1  digest valid.
- sha_digest_i  input  256  digest.
- busy_o  output  1  high in any state other than IDLE, DONE or ERR.
- done_o  output  1  level; comparison finished.
- pass_o  output  1  level; digest matched. Valid only while done_o is high.
- err_o  output  1  level; protocol or timeout error.
- block_cnt_o  output  CNT_W  blocks kicked since start_i; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0, except sha_reset_n_o = 0 (the core is held in reset). State = IDLE, word index = 0.
- All SHA-side outputs are registered.
- States: IDLE, SRST, LOAD, KICK, WAIT, CMP, DONE, ERR.
- IDLE/DONE/ERR on start_i:
  - clear done_o, pass_o, err_o, block_cnt_o and the first-block flag;
  - go to SRST.
- SRST:
  - drive sha_reset_n_o = 0 for exactly 2 cycles;
  - then release it (1) and go to LOAD.
  - sha_reset_n_o stays 1 from then until the next SRST.
- LOAD:
  - word_ready_o = 1.
  - On word_valid_i & word_ready_o, on the next cycle: sha_cs_o = sha_we_o = 1 for one cycle, sha_address_o = index, sha_write_data_o = word.
  - The index increments per accepted word.
  - Idle gaps on word_valid_i are allowed indefinitely.
- Block boundary: on acceptance at index 15, word_ready_o drops the next cycle and the state goes to KICK after the write cycle; the index wraps to 0.
- word_last_i on a word at index != 15: go to ERR (the word is still written) and assert err_o.
- word_last_i at index 15: set the final flag.
- KICK:
  - one-cycle sha_init_o if this is the first block, else one-cycle sha_next_o;
  - block_cnt_o increments (saturating);
  - go to WAIT.
- WAIT:
  - ignore sha_ready_i for the first cycle after the kick;
  - then wait for sha_ready_i = 1 with a cycle counter;
  - counter reaching TIMEOUT_CYCLES: go to ERR.
  - On ready: if the final flag is set, go to CMP, else go to LOAD.
- CMP:
  - requires sha_digest_valid_i = 1, otherwise go to ERR;
  - pass = (sha_digest_i == exp_digest_i);
  - go to DONE next cycle.
- DONE: done_o = 1, pass_o latched; both hold until start_i or reset.
- ERR: err_o = 1, done_o = 0, pass_o = 0; holds until start_i or reset.
- start_i while busy_o = 1 is ignored. word_valid_i outside LOAD is ignored (ready is low).
- Asynchronous reset mid-operation: immediate return to reset values, including sha_reset_n_o = 0.
- pass_o is never 1 while err_o is 1.
- Latency: a single-block message whose words are presented back-to-back gives done_o at cycles(SRST) 2 + LOAD 17 + KICK 1 + WAIT (core time + 1) + CMP 1.

Test Plan:
- Single block "abc", padded to 16 words (0x61626380, 0 x14, 0x00000018); exp = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  -> Exactly one sha_init_o and zero sha_next_o; block_cnt_o = 1; done_o = 1, pass_o = 1, err_o = 0.
- Two-block message (56-byte "abcdbcde...nopq" test vector), word_valid_i toggling randomly.
  -> Addresses 0..15 twice in order; init then next; block_cnt_o = 2; pass_o = 1.
- Same "abc" message, exp_digest_i bit 0 flipped.
  -> done_o = 1, pass_o = 0, err_o = 0.
- word_last_i asserted on word index 7.
  -> err_o = 1 the cycle after the handshake; no kick issued; block_cnt_o = 0.
- Model holds sha_ready_i = 0 after the kick.
  -> err_o rises exactly TIMEOUT_CYCLES (1024) cycles after the ignore cycle.
  -> A later start_i clears err_o and re-enters SRST.
- rst_ni pulsed low during LOAD at index 9.
  -> All outputs reset immediately, sha_reset_n_o = 0, state IDLE.
  -> A fresh start_i then runs "abc" to pass_o = 1.
